// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: drives the data-memory handshake and the MEM/WB register.
// Optional watchdog compiled in with `define MEM_TIMEOUT_EN. dbg_state: 0=IDLE, 1=BUSY, 2=DONE.
module mem_stage_ctrl #(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en_mem,
  input  logic         wd_sel_mem,
  input  logic         wm_en_mem,
  input  logic [4:0]   rw_mem,
  input  logic [N-1:0] alu_result_mem,
  input  logic [N-1:0] rdb_mem,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [N-1:0] dmem_rdata,
  output logic         stall,
  output logic         wr_en_wb,
  output logic [4:0]   rw_wb,
  output logic [N-1:0] wd_wb,
  output logic         mem_fault,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: dmem_req stays high from the edge that leaves IDLE until the edge
  // that samples dmem_ack=1 in BUSY; address, data and write strobe are stable meanwhile.
  logic [1:0]   state_q, state_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] buf_q, buf_d;
  logic         wr_en_wb_q, wr_en_wb_d;
  logic [4:0]   rw_wb_q, rw_wb_d;
  logic [N-1:0] wd_wb_q, wd_wb_d;
  logic         access;
  logic         wb_kill;

  assign access = wd_sel_mem | wm_en_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            fault_q, fault_d;

  assign wb_kill   = tmo_q;
  assign mem_fault = fault_q;
`else
  assign wb_kill   = 1'b0;
  // No watchdog: never faults.
  assign mem_fault = 1'b0 && (TIMEOUT != 0);
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    wr_en_wb_d = wr_en_wb_q;
    rw_wb_d    = rw_wb_q;
    wd_wb_d    = wd_wb_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    fault_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = wm_en_mem;
          addr_d  = alu_result_mem;
          wdata_d = rdb_mem;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          tmo_d   = 1'b0;
`endif
        end else begin
          wr_en_wb_d = wr_en_mem;
          rw_wb_d    = rw_mem;
          wd_wb_d    = alu_result_mem;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          buf_d   = dmem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TmoLast) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          tmo_d   = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // EX/MEM still holds the memory instruction here; it advances at this edge.
        state_d    = IDLE;
        rw_wb_d    = rw_mem;
        wd_wb_d    = wd_sel_mem ? buf_q : alu_result_mem;
        wr_en_wb_d = wr_en_mem & ~wm_en_mem & ~wb_kill;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      wr_en_wb_q <= 1'b0;
      rw_wb_q    <= '0;
      wd_wb_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      wr_en_wb_q <= wr_en_wb_d;
      rw_wb_q    <= rw_wb_d;
      wd_wb_q    <= wd_wb_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      fault_q    <= fault_d;
`endif
    end
  end

  // Only stall is combinational; reset masks it so the pipeline is free during reset.
  assign stall      = ~reset & ((state_q == BUSY) | ((state_q == IDLE) & access));
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wr_en_wb   = wr_en_wb_q;
  assign rw_wb      = rw_wb_q;
  assign wd_wb      = wd_wb_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases with literal expectations, then random
// instruction/ack traffic checked every cycle against an operation-level model.
module tb_mem_stage_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en_mem = 0, wd_sel_mem = 0, wm_en_mem = 0;
  logic [4:0]  rw_mem = 0;
  logic [31:0] alu_result_mem = 0, rdb_mem = 0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 0;
  logic [31:0] dmem_rdata = 0;
  logic        stall, wr_en_wb, mem_fault;
  logic [4:0]  rw_wb;
  logic [31:0] wd_wb;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_ctrl #(.N(32), .TIMEOUT(TMO)) dut (
    .clock(clk), .reset(reset),
    .wr_en_mem(wr_en_mem), .wd_sel_mem(wd_sel_mem), .wm_en_mem(wm_en_mem),
    .rw_mem(rw_mem), .alu_result_mem(alu_result_mem), .rdb_mem(rdb_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wr_en_wb(wr_en_wb), .rw_wb(rw_wb), .wd_wb(wd_wb), .mem_fault(mem_fault),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model: an outstanding memory op waits for ack (or watchdog),
  // then spends one completion cycle before the instruction retires.
  bit          op_open, op_retiring, op_timed_out;
  int          op_cycles;
  logic        m_req, m_we, m_wr, m_fault;
  logic [4:0]  m_rw;
  logic [31:0] m_addr, m_wdata, m_rd, m_wd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      op_open <= 0; op_retiring <= 0; op_timed_out <= 0; op_cycles <= 0;
      m_req <= 0; m_we <= 0; m_addr <= 0; m_wdata <= 0; m_rd <= 0;
      m_wr <= 0; m_rw <= 0; m_wd <= 0; m_fault <= 0;
    end else begin
      m_fault <= 0;
      if (op_retiring) begin
        op_retiring <= 0;
        m_rw <= rw_mem;
        m_wd <= wd_sel_mem ? m_rd : alu_result_mem;
        m_wr <= wr_en_mem && !wm_en_mem && !op_timed_out;
      end else if (op_open) begin
        if (dmem_ack) begin
          op_open <= 0; op_retiring <= 1; m_req <= 0; m_we <= 0; m_rd <= dmem_rdata;
        end else begin
          op_cycles <= op_cycles + 1;
`ifdef MEM_TIMEOUT_EN
          if (op_cycles + 1 == TMO) begin
            op_open <= 0; op_retiring <= 1; op_timed_out <= 1;
            m_req <= 0; m_we <= 0; m_fault <= 1;
          end
`endif
        end
      end else if (wd_sel_mem || wm_en_mem) begin
        op_open <= 1; op_timed_out <= 0; op_cycles <= 0;
        m_req <= 1; m_we <= wm_en_mem; m_addr <= alu_result_mem; m_wdata <= rdb_mem;
      end else begin
        m_wr <= wr_en_mem; m_rw <= rw_mem; m_wd <= alu_result_mem;
      end
    end
  end

  // scoreboard: registered outputs at negedge, stall once inputs have settled
  always @(negedge clk) begin
    chk("dmem_req", 32'(dmem_req), 32'(m_req));
    chk("dmem_we", 32'(dmem_we), 32'(m_we));
    chk("dmem_addr", dmem_addr, m_addr);
    chk("dmem_wdata", dmem_wdata, m_wdata);
    chk("wr_en_wb", 32'(wr_en_wb), 32'(m_wr));
    chk("rw_wb", 32'(rw_wb), 32'(m_rw));
    chk("wd_wb", wd_wb, m_wd);
    chk("mem_fault", 32'(mem_fault), 32'(m_fault));
    #4;
    chk("stall", 32'(stall),
        32'(!reset && (op_open || (!op_retiring && (wd_sel_mem || wm_en_mem)))));
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive_insn(input logic wr, input logic ld, input logic st, input logic [4:0] rw,
                            input logic [31:0] alu, input logic [31:0] rdb);
    wr_en_mem = wr; wd_sel_mem = ld; wm_en_mem = st;
    rw_mem = rw; alu_result_mem = alu; rdb_mem = rdb;
  endtask

  int stall_cycles;

  initial begin
    repeat (3) step();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_wr_en_wb", 32'(wr_en_wb), 0);
    chk("rst_wd_wb", wd_wb, 0);
    chk("rst_stall", 32'(stall), 0);
    reset = 0;

    // ALU op passes straight through
    step();
    drive_insn(1, 0, 0, 5'd5, 32'h1234, 0);
    #1 chk("alu_stall", 32'(stall), 0);
    step();
    chk("alu_rw_wb", 32'(rw_wb), 5);
    chk("alu_wd_wb", wd_wb, 32'h1234);
    chk("alu_wr_en_wb", 32'(wr_en_wb), 1);

    // load, ack in the second BUSY cycle
    drive_insn(1, 1, 0, 5'd7, 32'h40, 0);
    dmem_ack = 0; dmem_rdata = 32'hDEADBEEF;
    stall_cycles = 0;
    #1 if (stall) stall_cycles++;
    step();
    chk("ld_req", 32'(dmem_req), 1);
    chk("ld_addr", dmem_addr, 32'h40);
    chk("ld_we", 32'(dmem_we), 0);
    #1 if (stall) stall_cycles++;
    step();
    dmem_ack = 1;
    #1 if (stall) stall_cycles++;
    step();
    dmem_ack = 0;
    chk("ld_req_drop", 32'(dmem_req), 0);
    #1 if (stall) stall_cycles++;
    chk("ld_stall_cycles", 32'(stall_cycles), 3);
    step();
    chk("ld_wd_wb", wd_wb, 32'hDEADBEEF);
    chk("ld_wr_en_wb", 32'(wr_en_wb), 1);
    chk("ld_rw_wb", 32'(rw_wb), 7);

    // store; ack already high in IDLE must be ignored there
    drive_insn(1, 0, 1, 5'd9, 32'h80, 32'hA5A5A5A5);
    dmem_ack = 1;
    step();
    chk("st_req", 32'(dmem_req), 1);
    chk("st_we", 32'(dmem_we), 1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_addr", dmem_addr, 32'h80);
    step();
    dmem_ack = 0;
    chk("st_req_drop", 32'(dmem_req), 0);
    chk("st_we_drop", 32'(dmem_we), 0);
    step();
    chk("st_wr_en_wb", 32'(wr_en_wb), 0);

    // load+store together behaves as a store
    drive_insn(1, 1, 1, 5'd3, 32'hC0, 32'h11);
    step();
    chk("ldst_we", 32'(dmem_we), 1);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    step();
    chk("ldst_wr_en_wb", 32'(wr_en_wb), 0);

    // reset in the second BUSY cycle
    drive_insn(1, 1, 0, 5'd4, 32'h100, 0);
    step();
    step();
    reset = 1;
    #1 chk("rst_busy_req", 32'(dmem_req), 0);
    chk("rst_busy_stall", 32'(stall), 0);
    step();
    reset = 0;
    drive_insn(0, 0, 0, 0, 0, 0);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("post_rst_state", 32'(dbg_state), 0);
    chk("post_rst_req", 32'(dmem_req), 0);

`ifdef MEM_TIMEOUT_EN
    drive_insn(1, 1, 0, 5'd6, 32'h200, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tmo_req_held", 32'(dmem_req), 1);
    end
    step();
    chk("tmo_req_drop", 32'(dmem_req), 0);
    chk("tmo_fault", 32'(mem_fault), 1);
    step();
    chk("tmo_fault_clear", 32'(mem_fault), 0);
    chk("tmo_wr_en_wb", 32'(wr_en_wb), 0);
`endif

    // random traffic; a new instruction enters only once the previous one retired
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        step();
        reset = 0;
      end
      if (!op_open && !op_retiring)
        drive_insn(1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                   5'($urandom), $urandom, $urandom);
      dmem_ack   = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, datapath width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the watchdog limit in cycles, used only with MEM_TIMEOUT_EN.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports wr_en_mem, wd_sel_mem, wm_en_mem  input  1  each: register-write enable, load select and store enable from EX/MEM.
REQ-006 SHALL have port rw_mem  input  5  destination register from EX/MEM.
REQ-007 SHALL have ports alu_result_mem, rdb_mem  input  N  each: address/ALU result and store data from EX/MEM.
REQ-008 SHALL have ports dmem_req, dmem_we  output  1  each: data memory request and write strobe.
REQ-009 SHALL have ports dmem_addr, dmem_wdata  output  N  each: memory address and write data.
REQ-010 SHALL have ports dmem_ack  input  1  and dmem_rdata  input  N: memory completion and read data.
REQ-011 SHALL have port stall  output  1  freezes IF through EX/MEM when high.
REQ-012 SHALL have ports wr_en_wb  output  1, rw_wb  output  5 and wd_wb  output  N: MEM/WB register contents.
REQ-013 SHALL have port mem_fault  output  1  one-cycle timeout pulse.

Function
REQ-014 SHALL define access = wd_sel_mem | wm_en_mem.
REQ-015 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-016 In IDLE with access=0, SHALL load wr_en_wb/rw_wb/wd_wb from wr_en_mem/rw_mem/alu_result_mem every edge, keep stall=0 and stay in IDLE.
REQ-017 In IDLE with access=1, SHALL assert stall combinationally and hold the WB registers.
- At the edge: latch dmem_addr=alu_result_mem, dmem_wdata=rdb_mem, dmem_we=wm_en_mem; set dmem_req=1; go to BUSY.
REQ-018 In BUSY, SHALL hold stall=1 and dmem_req=1, with dmem_addr, dmem_wdata and dmem_we held stable.
REQ-019 In BUSY with dmem_ack=1, SHALL at that edge clear dmem_req and dmem_we, capture dmem_rdata into an internal buffer, and go to DONE.
- dmem_ack in the first BUSY cycle SHALL be accepted.
REQ-020 In DONE, SHALL hold stall=0.
- At the edge: load rw_wb=rw_mem and wd_wb=(wd_sel_mem ? buffer : alu_result_mem).
- Load wr_en_wb=wr_en_mem, except wr_en_wb=0 when wm_en_mem=1.
- Go to IDLE unconditionally; the next instruction is evaluated in IDLE.
REQ-021 SHALL give a memory instruction 3 cycles minimum occupancy: 1 IDLE + k BUSY + 1 DONE for an ack after k cycles.
REQ-022 SHALL treat wd_sel_mem=wm_en_mem=1 as a store: dmem_we=1 and wr_en_wb=0.
REQ-023 SHALL ignore dmem_ack outside BUSY.
REQ-024 SHALL register all outputs except stall, which is combinational from state and access and is forced to 0 while reset is high.

Reset
REQ-025 While reset is high, SHALL hold state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, buffer=0, wr_en_wb=0, rw_wb=0, wd_wb=0, mem_fault=0 and the watchdog counter=0.
REQ-026 Reset asserted mid-BUSY SHALL drop dmem_req immediately without waiting for a clock edge; a later ack SHALL be ignored.

Configuration
REQ-027 SHALL compile the watchdog in only when macro MEM_TIMEOUT_EN is defined.
- The counter clears on entry to BUSY and increments each BUSY cycle without ack.
- When it reaches TIMEOUT, the block SHALL clear dmem_req, go to DONE with wr_en_wb forced 0, and pulse mem_fault for one cycle.
REQ-028 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely for dmem_ack, and mem_fault SHALL be tied to 0.

Verification
REQ-029 SHALL cover ALU op: wr_en_mem=1, rw_mem=5, alu_result_mem=0x1234, access=0 -> stall=0; next edge rw_wb=5, wd_wb=0x1234, wr_en_wb=1.
REQ-030 SHALL cover load with ack 2 cycles after req: wd_sel_mem=1, alu_result_mem=0x40, dmem_rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x40, dmem_we=0; in DONE wd_wb=0xDEADBEEF, wr_en_wb=1.
REQ-031 SHALL cover store with immediate ack: wm_en_mem=1, rdb_mem=0xA5A5A5A5 -> dmem_we=1, dmem_wdata=0xA5A5A5A5 for 1 BUSY cycle; wr_en_wb=0.
REQ-032 SHALL cover reset asserted in the 2nd BUSY cycle -> dmem_req=0 and stall=0 asynchronously; after release, state=IDLE and an ack pulse has no effect.
REQ-033 SHALL cover MEM_TIMEOUT_EN defined with TIMEOUT=4 and no ack -> req drops after 4 BUSY cycles, mem_fault pulses once, wr_en_wb=0.
REQ-034 SHALL cover wd_sel_mem=wm_en_mem=1 -> dmem_we=1, wr_en_wb=0.
